// File: rtl/ex_pipe_regs_pkg.sv
// Shared opcode constants and writeback decode for the EX/MEM/WB register chain
// and the forwarding unit.
package ex_pipe_regs_pkg;

  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_OP_IMM = 5'b00100;
  localparam logic [4:0] OPC_AUIPC  = 5'b00101;
  localparam logic [4:0] OPC_OP     = 5'b01100;
  localparam logic [4:0] OPC_LUI    = 5'b01101;
  localparam logic [4:0] OPC_JALR   = 5'b11001;
  localparam logic [4:0] OPC_JAL    = 5'b11011;

  // addi x0,x0,0 : rd=rs1=rs2=0, so a bubble never forwards or writes back
  localparam logic [31:0] NOP = 32'h0000_0013;

  function automatic logic writes_rd(input logic [4:0] opc);
    case (opc)
      OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_LUI,
      OPC_AUIPC, OPC_JAL, OPC_JALR: return 1'b1;
      default:                      return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ex_pipe_regs_hazard_detect.sv
// Load-use detector: a load in EXE whose rd is read by the instruction in ID.
// Conservative: rs1/rs2 fields are compared whatever the ID format.
module hazard_detect
  import ex_pipe_regs_pkg::*;
#(
  parameter int IW = 32
) (
  input  logic [IW-1:0] id_inst,
  input  logic [IW-1:0] exeinst,
  output logic          hazard
);

  logic [4:0] ex_rd;
  logic       unused_bits;

  assign ex_rd  = exeinst[11:7];
  assign hazard = (exeinst[6:2] == OPC_LOAD) && (ex_rd != 5'd0) &&
                  ((ex_rd == id_inst[19:15]) || (ex_rd == id_inst[24:20]));

  assign unused_bits = ^{id_inst[IW-1:25], id_inst[14:0],
                         exeinst[IW-1:12], exeinst[1:0]};

endmodule

// File: rtl/ex_pipe_regs.sv
// ID/EX -> EX/MEM -> MEM/WB register chain with load-use stall, branch flush,
// memory-busy freeze and a saturating stall-cycle counter.
module ex_pipe_regs
  import ex_pipe_regs_pkg::*;
#(
  parameter int RFW = 5,
  parameter int DW  = 32,
  parameter int IW  = 32,
  parameter int CW  = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [IW-1:0]  id_inst,
  input  logic           flush,
  input  logic           mem_busy,
  input  logic [DW-1:0]  alu_result,
  input  logic [DW-1:0]  mem_rdata,
  output logic           stall_out,
  output logic [IW-1:0]  exeinst,
  output logic [IW-1:0]  meminst,
  output logic [DW-1:0]  memdata,
  output logic           wb_we,
  output logic [RFW-1:0] wb_rd,
  output logic [DW-1:0]  wb_data,
  output logic [CW-1:0]  stall_cnt
);

  localparam logic [IW-1:0] NOP_I = IW'(NOP);

  logic          hazard;
  logic [DW-1:0] exmem_res;
  logic [IW-1:0] wb_inst;
  logic [DW-1:0] wb_res;
  logic          unused_wb;

  hazard_detect #(.IW(IW)) u_hazard (
    .id_inst (id_inst),
    .exeinst (exeinst),
    .hazard  (hazard)
  );

  // a flushed dependent instruction is dead, so it needs no stall
  assign stall_out = mem_busy | (hazard & ~flush);
  assign memdata   = (meminst[6:2] == OPC_LOAD) ? mem_rdata : exmem_res;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exeinst   <= NOP_I;
      meminst   <= NOP_I;
      exmem_res <= '0;
      wb_inst   <= NOP_I;
      wb_res    <= '0;
    end else if (!mem_busy) begin
      exeinst   <= (flush | hazard) ? NOP_I : id_inst;
      meminst   <= exeinst;
      exmem_res <= alu_result;
      wb_inst   <= meminst;
      wb_res    <= memdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cnt <= '0;
    else if (stall_out && (stall_cnt != '1))
      stall_cnt <= stall_cnt + CW'(1);
  end

  assign wb_we   = writes_rd(wb_inst[6:2]) && (wb_inst[11:7] != 5'd0);
  assign wb_rd   = RFW'(wb_inst[11:7]);
  assign wb_data = wb_res;

  assign unused_wb = ^{wb_inst[IW-1:12], wb_inst[1:0]};

endmodule

// File: doc/ex_pipe_regs.md
# ex_pipe_regs

Pipeline register chain ID/EX → EX/MEM → MEM/WB that produces the `exeinst`, `meminst` and `memdata` values consumed by the forwarding unit. It also drives the register-file writeback fields. The block detects load-use hazards, raises a stall towards fetch/decode and inserts bubbles. It also handles branch flush, honours a memory-busy freeze and counts stall cycles.

## Interface
Parameters:
- `RFW`, 5, register index width
- `DW`, 32, data width
- `IW`, 32, instruction width
- `CW`, 32, stall counter width

Ports:
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `id_inst`  in  IW  instruction leaving decode
- `flush`  in  1  branch taken; squash the instruction in ID
- `mem_busy`  in  1  data memory not ready; freeze the whole chain
- `alu_result`  in  DW  combinational ALU output for `exeinst`
- `mem_rdata`  in  DW  load data, valid during MEM stage
- `stall_out`  out  1  hold PC and IF/ID this cycle
- `exeinst`  out  IW  instruction in EXE (ID/EX register)
- `meminst`  out  IW  instruction in MEM (EX/MEM register)
- `memdata`  out  DW  result of `meminst`
- `wb_we`  out  1  register-file write enable
- `wb_rd`  out  RFW  writeback destination
- `wb_data`  out  DW  writeback value
- `stall_cnt`  out  CW  saturating count of `stall_out` cycles

## Operation
- Field extraction:
  - opcode = inst[6:2]
  - rd = [11:7]
  - rs1 = [19:15]
  - rs2 = [24:20]
- NOP = 32'h0000_0013 (addi x0,x0,0). A bubble is always NOP, so rd=0 and nothing forwards from it.
- Load-use hazard: `exeinst` opcode == LOAD, rd(exeinst) != 0, and rd(exeinst) equals rs1 or rs2 of `id_inst`. The check is conservative and applies regardless of the `id_inst` format.
- `stall_out` = `mem_busy` | (hazard & ~`flush`).
- Per-edge update when `mem_busy`=1: all registers hold. `stall_cnt` still increments.
- Per-edge update when `mem_busy`=0:
  - ID/EX ← NOP if `flush` or hazard, else `id_inst`.
  - EX/MEM ← {`exeinst`, `alu_result`}.
  - MEM/WB ← {`meminst`, `memdata`}.
- `memdata` = `mem_rdata` when `meminst` opcode == LOAD, else the EX/MEM result register.
- Writeback decode, from the MEM/WB register:
  - `wb_we` = 1 when opcode ∈ {OP, OP_IMM, LOAD, LUI, AUIPC, JAL, JALR} and rd != 0.
  - `wb_rd` = rd.
  - `wb_data` = registered result.
- `flush` is sampled only when `mem_busy`=0. The source holds `flush` until then.
- `stall_cnt` increments by 1 on each edge where `stall_out`=1 and saturates at all-ones.

## Timing
- Reset (async assert, sync release):
  - ID/EX, EX/MEM, MEM/WB instructions = NOP.
  - Data registers = 0.
  - `stall_cnt` = 0.
  - Consequently `wb_we`=0, `stall_out` = `mem_busy`.
- Latency: `id_inst` appears on `exeinst` 1 cycle later, on `meminst` 2 cycles later, and on the `wb_*` outputs 3 cycles later.
- `stall_out`, `memdata` and `wb_*` are combinational from registers and inputs; there is no additional register stage.
- A load-use hazard produces exactly one stall cycle when `mem_busy` is low. The next cycle, the load sits in MEM and is forwarded from `memdata` via the WB path or by the forwarding unit's MEM slot.
- `flush` and hazard in the same cycle: bubble inserted, `stall_out`=0 (the dependent instruction is dead).
- `mem_busy` during a hazard: freeze takes precedence. The hazard re-evaluates after `mem_busy` falls and still yields one bubble.
- Reset mid-operation: all in-flight instructions are discarded immediately. No `wb_we` pulse is generated.

## Structure
- OP, OP_IMM, LOAD, LUI, AUIPC, JAL, JALR opcode constants and NOP go in `hdl/definitions.v`, shared with the forwarding unit.
- One sub-module is natural: `hazard_detect`, combinational, taking `id_inst` and `exeinst` and producing the hazard flag.
- Everything else lives in the top module.

## Test plan
- Reset: hold `rst_n`=0 with random inputs → `exeinst`=`meminst`=NOP, `wb_we`=0, `stall_cnt`=0.
- Independent stream of 3 OP instructions:
  - Stimulus: `add x1`, `add x2`, `add x3`, each `alu_result`=0x11/0x22/0x33.
  - Response: `wb_rd`=1, 2, 3 with `wb_data`=0x11, 0x22, 0x33 on cycles 3, 4, 5; `stall_out` never 1.
- Load-use:
  - Stimulus: `lw x5` followed by `add x6,x5,x7`.
  - Response: `stall_out`=1 for exactly 1 cycle; `exeinst`=NOP in the following cycle; `stall_cnt`=1.
  - Variant: `lw x0` followed by `add x6,x0,x0` → no stall.
- Load data: `lw x5` with `mem_rdata`=0xDEADBEEF during MEM → `memdata`=0xDEADBEEF; next cycle `wb_data`=0xDEADBEEF, `wb_rd`=5.
- Flush plus hazard in the same cycle → `stall_out`=0, `exeinst`=NOP next cycle, counter unchanged.
- `mem_busy` held high for 4 cycles mid-stream → all outputs stable, `stall_cnt` +4. Resuming gives the same sequence as the unfrozen run.
